bus_cycle_controller: RTL and testbench

BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

---
 rtl/bus_cycle_controller_pkg.sv | 66 ++++++
 rtl/bus_cycle_controller_sync.sv | 37 +++
 rtl/bus_cycle_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_bus_cycle_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_controller_pkg.sv
// ----------------------------------------------------------------------------
// bus_cycle_controller_pkg
// Shared types and constants for the 68000 bus cycle controller:
//   - FSM state encoding
//   - region codes produced by the address/function-code decoder
//   - memory map constants (A[23:20]) and the interrupt-acknowledge FC
//   - the registered output bundle and its idle value
// ----------------------------------------------------------------------------
package bus_cycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REG_PROM     = 2'd0,
    REG_SRAM     = 2'd1,
    REG_UNMAPPED = 2'd2,
    REG_IACK     = 2'd3
  } region_e;

  localparam logic [3:0] PROM_BASE = 4'h0;
  localparam logic [3:0] SRAM_BASE = 4'h1;
  localparam logic [2:0] IACK_FC   = 3'b111;

  // All controller outputs travel together through one register stage.
  typedef struct packed {
    logic dtack_n;
    logic berr_n;
    logic avec_n;
    logic sramcs0_n;
    logic sramcs1_n;
    logic promcs0_n;
    logic promcs1_n;
    logic oe_n;
    logic busy;
  } bus_out_t;

  localparam bus_out_t OUT_IDLE = '{
    dtack_n:   1'b1,
    berr_n:    1'b1,
    avec_n:    1'b1,
    sramcs0_n: 1'b1,
    sramcs1_n: 1'b1,
    promcs0_n: 1'b1,
    promcs1_n: 1'b1,
    oe_n:      1'b1,
    busy:      1'b0
  };

  // Interrupt acknowledge wins over the address map.
  function automatic region_e decode_region(input logic [2:0] fc,
                                            input logic [3:0] a);
    region_e r;
    if (fc == IACK_FC)        r = REG_IACK;
    else if (a == PROM_BASE)  r = REG_PROM;
    else if (a == SRAM_BASE)  r = REG_SRAM;
    else                      r = REG_UNMAPPED;
    return r;
  endfunction

endpackage

// File: rtl/bus_cycle_controller_sync.sv
// ----------------------------------------------------------------------------
// strobe_sync
// Parameterized-width two-flop synchronizer for the asynchronous CPU bus
// inputs.
//   clk  : destination clock
//   rst  : asynchronous, active-high reset
//   d    : raw asynchronous inputs
//   q    : synchronized outputs (two clock edges of latency)
// RESET_VAL sets the level both stages take in reset, so active-low strobes
// can come out of reset as "inactive" rather than "asserted".
// ----------------------------------------------------------------------------
module strobe_sync #(
  parameter int unsigned         WIDTH     = 1,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: reset to the inactive bus level, not zero; a zero here would
      // look like an asserted active-low strobe the moment reset releases.
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so q takes the previous meta, giving two stages.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_cycle_controller.sv
// ----------------------------------------------------------------------------
// bus_cycle_controller
// 68000 bus cycle controller: decodes each CPU bus cycle into PROM, SRAM,
// unmapped or interrupt-acknowledge, inserts the region's wait states, and
// terminates the cycle with DTACK, AVEC or BERR. A watchdog turns any cycle
// that runs too long into a bus error.
// Ports:
//   CPUCLK_IN            : single clock (the 68000 clock)
//   RESET                : asynchronous, active-high reset
//   AS_n, UDS_n, LDS_n   : CPU address / data strobes (active low, async)
//   RW                   : 1 = read, 0 = write
//   FC[2:0]              : CPU function code
//   A[3:0]               : CPU address bits 23..20
//   DTACK_n, BERR_n, AVEC_n : cycle termination (active low)
//   SRAMCS0_n/1_n        : SRAM upper/lower byte selects
//   PROMCS0_n/1_n        : PROM upper/lower byte selects
//   OE_n                 : memory output enable
//   BUSY                 : a cycle is in progress
// All outputs are registered.
// ----------------------------------------------------------------------------
module bus_cycle_controller
  import bus_cycle_controller_pkg::*;
#(
  parameter int unsigned PROM_WAIT    = 2,
  parameter int unsigned SRAM_WAIT    = 0,
  parameter int unsigned BERR_TIMEOUT = 64
) (
  input  logic       CPUCLK_IN,
  input  logic       RESET,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic [2:0] FC,
  input  logic [3:0] A,
  output logic       DTACK_n,
  output logic       BERR_n,
  output logic       AVEC_n,
  output logic       SRAMCS0_n,
  output logic       SRAMCS1_n,
  output logic       PROMCS0_n,
  output logic       PROMCS1_n,
  output logic       OE_n,
  output logic       BUSY
);

  localparam int unsigned SYNC_W      = 11;
  // Strobes and RW idle high; FC and A idle at zero.
  localparam logic [SYNC_W-1:0] SYNC_RST = 11'b1111_000_0000;
  localparam logic [7:0]  TIMEOUT_CNT = 8'(BERR_TIMEOUT);

  // --------------------------------------------------------------------------
  // Input synchronization
  // --------------------------------------------------------------------------
  logic [SYNC_W-1:0] sync_q;
  logic              as_n_s, uds_n_s, lds_n_s, rw_s;
  logic [2:0]        fc_s;
  logic [3:0]        a_s;

  strobe_sync #(
    .WIDTH    (SYNC_W),
    .RESET_VAL(SYNC_RST)
  ) u_sync (
    .clk(CPUCLK_IN),
    .rst(RESET),
    .d  ({AS_n, UDS_n, LDS_n, RW, FC, A}),
    .q  (sync_q)
  );

  assign {as_n_s, uds_n_s, lds_n_s, rw_s, fc_s, a_s} = sync_q;

  logic    as_act, uds_act, lds_act;
  region_e live_region;

  assign as_act      = ~as_n_s;
  assign uds_act     = ~uds_n_s;
  assign lds_act     = ~lds_n_s;
  assign live_region = decode_region(fc_s, a_s);

  function automatic logic [3:0] wait_load(input region_e r);
    logic [3:0] w;
    case (r)
      REG_PROM: w = 4'(PROM_WAIT);
      REG_SRAM: w = 4'(SRAM_WAIT);
      default:  w = 4'd0;
    endcase
    return w;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e     state_q, state_d;
  region_e    region_q, region_d;
  logic       rw_q, rw_d;
  logic       uds_q, uds_d;
  logic       lds_q, lds_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] wd_q, wd_d;
  bus_out_t   out_q, out_d;

  always_ff @(posedge CPUCLK_IN or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      region_q <= REG_UNMAPPED;
      rw_q     <= 1'b1;
      uds_q    <= 1'b0;
      lds_q    <= 1'b0;
      wait_q   <= '0;
      wd_q     <= '0;
      out_q    <= OUT_IDLE;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      rw_q     <= rw_d;
      uds_q    <= uds_d;
      lds_q    <= lds_d;
      wait_q   <= wait_d;
      wd_q     <= wd_d;
      out_q    <= out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch.
    state_d  = state_q;
    region_d = region_q;
    rw_d     = rw_q;
    uds_d    = uds_q;
    lds_d    = lds_q;
    wait_d   = wait_q;
    wd_d     = wd_q;

    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        wd_d   = '0;
        if (as_act && (uds_act || lds_act || live_region == REG_IACK))
          state_d = ST_DECODE;
      end

      ST_DECODE: begin
        region_d = live_region;
        rw_d     = rw_s;
        uds_d    = uds_act;
        lds_d    = lds_act;
        wait_d   = wait_load(live_region);
        wd_d     = wd_q + 8'd1;
        if (!as_act)                                state_d = ST_IDLE;
        else if (wd_d == TIMEOUT_CNT)               state_d = ST_FAULT;
        else if (live_region == REG_PROM && !rw_s)  state_d = ST_FAULT;
        else if (live_region == REG_IACK)           state_d = ST_ACK;
        else if (live_region == REG_UNMAPPED)       state_d = ST_WAIT;
        else if (wait_d == 4'd0)                    state_d = ST_ACK;
        else                                        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        wd_d = wd_q + 8'd1;
        // Unmapped cycles have no terminal count; only the watchdog ends them.
        if (region_q != REG_UNMAPPED)
          wait_d = wait_q - 4'd1;
        if (!as_act)                      state_d = ST_IDLE;
        else if (wd_d == TIMEOUT_CNT)     state_d = ST_FAULT;
        else if (region_q != REG_UNMAPPED && wait_d == 4'd0)
                                          state_d = ST_ACK;
      end

      ST_ACK, ST_FAULT: begin
        if (!as_act) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic, computed from the next state so the registered outputs
  // change on the same edge as the state. region_d/rw_d/lanes equal the
  // latched values except in DECODE, where they carry the live decode.
  // --------------------------------------------------------------------------
  always_comb begin
    logic cs_on;
    logic any_cs;

    out_d      = OUT_IDLE;
    out_d.busy = (state_d != ST_IDLE);
    cs_on      = (state_d == ST_WAIT) || (state_d == ST_ACK);

    if (cs_on && region_d == REG_PROM) begin
      out_d.promcs0_n = ~uds_d;
      out_d.promcs1_n = ~lds_d;
    end
    if (cs_on && region_d == REG_SRAM) begin
      out_d.sramcs0_n = ~uds_d;
      out_d.sramcs1_n = ~lds_d;
    end

    any_cs     = ~(out_d.promcs0_n & out_d.promcs1_n &
                   out_d.sramcs0_n & out_d.sramcs1_n);
    out_d.oe_n = ~(any_cs & rw_d);

    out_d.dtack_n = ~((state_d == ST_ACK) &&
                      (region_d == REG_PROM || region_d == REG_SRAM));
    out_d.avec_n  = ~((state_d == ST_ACK) && (region_d == REG_IACK));
    out_d.berr_n  = ~(state_d == ST_FAULT);
  end

  assign DTACK_n   = out_q.dtack_n;
  assign BERR_n    = out_q.berr_n;
  assign AVEC_n    = out_q.avec_n;
  assign SRAMCS0_n = out_q.sramcs0_n;
  assign SRAMCS1_n = out_q.sramcs1_n;
  assign PROMCS0_n = out_q.promcs0_n;
  assign PROMCS1_n = out_q.promcs1_n;
  assign OE_n      = out_q.oe_n;
  assign BUSY      = out_q.busy;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// ----------------------------------------------------------------------------
// tb_bus_cycle_controller
// Self-checking bench for bus_cycle_controller. Each bus cycle is driven on a
// falling edge and the outputs are sampled on every following falling edge.
// The expected output vector at sample j is derived from the cycle timeline:
// sync visible at sample 2, DECODE at 3, termination at 4+N (or at DECODE +
// BERR_TIMEOUT for unmapped), idle three samples after AS is released.
// ----------------------------------------------------------------------------
module tb_bus_cycle_controller;

  localparam int PROM_WAIT    = 2;
  localparam int SRAM_WAIT    = 0;
  localparam int BERR_TIMEOUT = 64;

  logic       CPUCLK_IN = 1'b0;
  logic       RESET     = 1'b1;
  logic       AS_n      = 1'b1;
  logic       UDS_n     = 1'b1;
  logic       LDS_n     = 1'b1;
  logic       RW        = 1'b1;
  logic [2:0] FC        = 3'd0;
  logic [3:0] A         = 4'd0;
  logic DTACK_n, BERR_n, AVEC_n, SRAMCS0_n, SRAMCS1_n;
  logic PROMCS0_n, PROMCS1_n, OE_n, BUSY;

  bus_cycle_controller #(
    .PROM_WAIT   (PROM_WAIT),
    .SRAM_WAIT   (SRAM_WAIT),
    .BERR_TIMEOUT(BERR_TIMEOUT)
  ) dut (
    .CPUCLK_IN(CPUCLK_IN),
    .RESET    (RESET),
    .AS_n     (AS_n),
    .UDS_n    (UDS_n),
    .LDS_n    (LDS_n),
    .RW       (RW),
    .FC       (FC),
    .A        (A),
    .DTACK_n  (DTACK_n),
    .BERR_n   (BERR_n),
    .AVEC_n   (AVEC_n),
    .SRAMCS0_n(SRAMCS0_n),
    .SRAMCS1_n(SRAMCS1_n),
    .PROMCS0_n(PROMCS0_n),
    .PROMCS1_n(PROMCS1_n),
    .OE_n     (OE_n),
    .BUSY     (BUSY)
  );

  always #5 CPUCLK_IN = ~CPUCLK_IN;

  int n_checks = 0;
  int n_fail   = 0;

  // Vector order: {BUSY, OE_n, PROMCS1_n, PROMCS0_n, SRAMCS1_n, SRAMCS0_n,
  //                AVEC_n, BERR_n, DTACK_n}
  localparam logic [8:0] IDLE_VEC = 9'h0FF;

  function automatic logic [8:0] observed();
    return {BUSY, OE_n, PROMCS1_n, PROMCS0_n, SRAMCS1_n, SRAMCS0_n,
            AVEC_n, BERR_n, DTACK_n};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  // Reference for one sample of a cycle. t = first terminated sample,
  // r = sample after which AS was released.
  function automatic logic [8:0] expect_vec(
      input int j, input int r, input int t, input bit start,
      input bit iack, input bit prom, input bit sram, input bit unm,
      input bit rw, input bit uds, input bit lds);
    bit busy, term, csw, p0, p1, s0, s1, oe, dt, av, be;
    busy = start && (j >= 3) && (j <= r + 2);
    term = busy && (j >= t);
    csw  = busy && (j >= 4) && ((prom && rw) || sram);
    p0   = csw && prom && uds;
    p1   = csw && prom && lds;
    s0   = csw && sram && uds;
    s1   = csw && sram && lds;
    oe   = (p0 || p1 || s0 || s1) && rw;
    dt   = term && ((prom && rw) || sram);
    av   = term && iack;
    be   = term && ((prom && !rw) || unm);
    return {busy, !oe, !p1, !p0, !s1, !s0, !av, !be, !dt};
  endfunction

  // mode 0: run to termination, 1: release AS early, 2: pulse RESET mid-cycle
  task automatic run_txn(input string name, input logic [3:0] a_v,
                         input logic [2:0] fc_v, input bit rw_v,
                         input bit uds_v, input bit lds_v, input int mode);
    bit iack, prom, sram, unm, start, restarted;
    int n, t, r, rs, j;
    iack  = (fc_v == 3'b111);
    prom  = !iack && (a_v == 4'h0);
    sram  = !iack && (a_v == 4'h1);
    unm   = !iack && !prom && !sram;
    start = iack || uds_v || lds_v;
    n     = prom ? PROM_WAIT : (sram ? SRAM_WAIT : 0);
    if (iack || (prom && !rw_v)) t = 4;
    else if (unm)                t = 3 + BERR_TIMEOUT;
    else                         t = 4 + n;
    rs = 0;
    if (!start)         r = 6;
    else if (mode == 1) r = $urandom_range(1, (t - 3 < 1) ? 1 : t - 3);
    else                r = t + int'($urandom_range(0, 3));
    if (mode == 2) rs = $urandom_range(3, t - 1);

    @(negedge CPUCLK_IN);
    AS_n = 1'b0; UDS_n = !uds_v; LDS_n = !lds_v;
    RW = rw_v; FC = fc_v; A = a_v;

    j = 0;
    restarted = 1'b0;
    while (j < r + 5) begin
      @(posedge CPUCLK_IN);
      @(negedge CPUCLK_IN);
      j++;
      check($sformatf("%s j=%0d", name, j), 32'(observed()),
            32'(expect_vec(j, r, t, start, iack, prom, sram, unm,
                           rw_v, uds_v, lds_v)));
      if (mode == 2 && start && !restarted && j == rs) begin
        RESET = 1'b1;
        #1;
        check($sformatf("%s rst_async", name), 32'(observed()), 32'(IDLE_VEC));
        @(posedge CPUCLK_IN);
        @(negedge CPUCLK_IN);
        check($sformatf("%s rst_held", name), 32'(observed()), 32'(IDLE_VEC));
        RESET = 1'b0;
        restarted = 1'b1;
        j = 0;
      end else if (j == r) begin
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] a_r;
    logic [2:0] fc_r;
    int         k, mode, lanes;

    repeat (2) @(negedge CPUCLK_IN);
    check("reset_state", 32'(observed()), 32'(IDLE_VEC));
    RESET = 1'b0;
    repeat (2) begin
      @(negedge CPUCLK_IN);
      check("post_reset_idle", 32'(observed()), 32'(IDLE_VEC));
    end

    // Directed cycles
    run_txn("sram_rd_both",   4'h1, 3'd5, 1'b1, 1'b1, 1'b1, 0);
    run_txn("prom_rd_lds",    4'h0, 3'd6, 1'b1, 1'b0, 1'b1, 0);
    run_txn("prom_wr",        4'h0, 3'd5, 1'b0, 1'b1, 1'b1, 0);
    run_txn("unmapped_rd",    4'h5, 3'd5, 1'b1, 1'b1, 1'b1, 0);
    run_txn("iack",           4'h3, 3'd7, 1'b1, 1'b0, 1'b0, 0);
    run_txn("prom_abort",     4'h0, 3'd6, 1'b1, 1'b1, 1'b1, 1);
    run_txn("prom_reset",     4'h0, 3'd6, 1'b1, 1'b1, 1'b0, 2);
    run_txn("sram_wr_uds",    4'h1, 3'd1, 1'b0, 1'b1, 1'b0, 0);
    run_txn("no_strobe",      4'h1, 3'd5, 1'b1, 1'b0, 1'b0, 0);

    // Randomized cycles
    for (int i = 0; i < 120; i++) begin
      k = $urandom_range(0, 9);
      fc_r = 3'($urandom_range(0, 6));
      if (k <= 3)      a_r = 4'h1;
      else if (k <= 6) a_r = 4'h0;
      else if (k == 7) a_r = 4'($urandom_range(2, 15));
      else begin
        a_r  = 4'($urandom_range(0, 15));
        fc_r = 3'b111;
      end
      lanes = $urandom_range(0, 7);
      if (lanes > 3) lanes = 3;
      mode = $urandom_range(0, 5);
      if (mode > 2) mode = 0;
      run_txn($sformatf("rnd%0d", i), a_r, fc_r, 1'($urandom_range(0, 1)),
              lanes[1], lanes[0], mode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
